// File: rtl/debouncer_bank_if.sv
// Signal bundle for debouncer_bank: raw switch inputs and their debounced
// level, edge strobes, change flag and long-press strobes.
// There is no valid/ready handshake. signal_in is sampled on every clock.
// Each output is a registered level or a strobe that is valid for one cycle.
interface debouncer_bank_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] signal_in;
    logic [WIDTH-1:0] signal_out;
    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;
    logic             any_change;
    logic [WIDTH-1:0] long_pulse;

    // Board side or stimulus: drives the raw pins and observes the results.
    modport master (
        output signal_in,
        input  signal_out, rise_pulse, fall_pulse, any_change, long_pulse
    );

    // Debouncer side.
    modport slave (
        input  signal_in,
        output signal_out, rise_pulse, fall_pulse, any_change, long_pulse
    );
endinterface

// File: rtl/debouncer_bank.sv
// debouncer_bank: WIDTH independent switch debouncers. Each channel has a
// synchroniser chain followed by a down-counter filter. The outputs are the
// debounced levels, one-cycle rise/fall strobes and a combined change flag.
// The optional long-press detector is enabled by DEBOUNCER_BANK_LONG_PRESS_EN.
// When that macro is not defined, long_pulse is tied to 0.
module debouncer_bank #(
    parameter int               WIDTH       = 4,
    parameter int               FILTER      = 200_000_000,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] INIT_VAL    = '0,
    parameter int               LONG_FILTER = 400_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    debouncer_bank_if.slave   bus
);
    localparam int          CW     = $clog2(FILTER);
    localparam logic [CW-1:0] RELOAD = CW'(FILTER - 1);

    // Reject configurations the filter cannot represent.
    if (WIDTH < 1 || WIDTH > 32 || FILTER < 2 || SYNC_STAGES < 2 ||
        SYNC_STAGES > 4 || LONG_FILTER < 2) begin : g_bad_params
        $error("debouncer_bank: parameter out of range");
    end

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [CW-1:0]    cnt_q  [WIDTH];
    logic [CW-1:0]    cnt_d  [WIDTH];
    logic [WIDTH-1:0] signal_out_q, signal_out_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             any_q, any_d;
    logic [WIDTH-1:0] sync_last;

    assign sync_last = sync_q[SYNC_STAGES-1];

    // Shift the raw pins through the synchroniser chain.
    always_comb begin
        sync_d[0] = bus.signal_in;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    // Per-channel filter: reload on agreement, accept the new level when the
    // counter has reached zero, otherwise count down.
    always_comb begin
        signal_out_d = signal_out_q;
        rise_d       = '0;
        fall_d       = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync_last[i] == signal_out_q[i]) begin
                cnt_d[i] = RELOAD;
            end else if (cnt_q[i] == '0) begin
                signal_out_d[i] = sync_last[i];
                cnt_d[i]        = RELOAD;
                rise_d[i]       = sync_last[i];
                fall_d[i]       = ~sync_last[i];
            end else begin
                cnt_d[i] = cnt_q[i] - CW'(1);
            end
        end
        any_d = |(rise_d | fall_d);
    end

    // State registers. Reset never samples the pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= INIT_VAL;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= RELOAD;
            signal_out_q <= INIT_VAL;
            rise_q       <= '0;
            fall_q       <= '0;
            any_q        <= 1'b0;
        end else begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= sync_d[s];
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
            signal_out_q <= signal_out_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            any_q        <= any_d;
        end
    end

    assign bus.signal_out = signal_out_q;
    assign bus.rise_pulse = rise_q;
    assign bus.fall_pulse = fall_q;
    assign bus.any_change = any_q;

`ifdef DEBOUNCER_BANK_LONG_PRESS_EN
    localparam int             LCW     = $clog2(LONG_FILTER);
    localparam logic [LCW-1:0] LRELOAD = LCW'(LONG_FILTER - 1);

    logic [LCW-1:0]   long_cnt_q [WIDTH];
    logic [LCW-1:0]   long_cnt_d [WIDTH];
    logic [WIDTH-1:0] fired_q, fired_d;
    logic [WIDTH-1:0] long_q, long_d;

    // Long-press timer. It counts while the level is high and fires once when
    // it reaches zero. It holds at zero until the level drops.
    always_comb begin
        fired_d = fired_q;
        long_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            long_cnt_d[i] = long_cnt_q[i];
            if (!signal_out_q[i]) begin
                long_cnt_d[i] = LRELOAD;
                fired_d[i]    = 1'b0;
            end else if (long_cnt_q[i] != '0) begin
                long_cnt_d[i] = long_cnt_q[i] - LCW'(1);
            end else if (!fired_q[i]) begin
                long_d[i]  = 1'b1;
                fired_d[i] = 1'b1;
            end
        end
    end

    // Long-press registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) long_cnt_q[i] <= LRELOAD;
            fired_q <= '0;
            long_q  <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) long_cnt_q[i] <= long_cnt_d[i];
            fired_q <= fired_d;
            long_q  <= long_d;
        end
    end

    assign bus.long_pulse = long_q;
`else
    assign bus.long_pulse = '0;
`endif
endmodule

// File: doc/debouncer_bank.md
Name: debouncer_bank

Overview:
Multi-channel switch/button debouncer with per-channel edge and change reporting.
Each of WIDTH asynchronous inputs is synchronised, then filtered by an independent down-counter.
Emits debounced levels plus one-cycle rise/fall strobes.
Sits between board pins (buttons, DIP switches) and the control logic, so one instance replaces a group of single-channel debouncers.

Parameters:
WIDTH, 4, number of independent channels (1..32)
FILTER, 200_000_000, consecutive differing clocks needed to accept a new level (>= 2)
SYNC_STAGES, 2, synchroniser flops per channel (2..4)
INIT_VAL, {WIDTH{1'b0}}, reset value of synchroniser flops and signal_out
LONG_FILTER, 400_000_000, clocks signal_out must stay 1 before long_pulse fires (>= 2; used only with the optional feature)

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
signal_in  in  WIDTH  raw, undebounced, asynchronous inputs
signal_out  out  WIDTH  debounced levels
rise_pulse  out  WIDTH  1-cycle strobe when signal_out[i] goes 0->1
fall_pulse  out  WIDTH  1-cycle strobe when signal_out[i] goes 1->0
any_change  out  1  OR of rise_pulse|fall_pulse, registered in the same cycle
long_pulse  out  WIDTH  1-cycle long-press strobe (optional feature)

Behaviour:
- Reset (rst_n low, takes effect without a clock edge):
  - sync flops = INIT_VAL; signal_out = INIT_VAL
  - all counters = FILTER-1 (RELOAD)
  - rise_pulse / fall_pulse / any_change / long_pulse = 0
  - Reset never loads signal_in.
  - No strobe is produced by reset assertion or deassertion.
- Synchroniser: per channel, SYNC_STAGES-deep flop chain; sync[i] is the last stage.
- Counter width: clogb2(FILTER) bits per channel. Each channel is independent. Every clock:
  - sync[i] == signal_out[i]: cnt[i] <= RELOAD.
  - sync[i] != signal_out[i] and cnt[i] == 0: signal_out[i] <= sync[i]; cnt[i] <= RELOAD; matching rise_pulse[i] or fall_pulse[i] <= 1 on the same edge.
  - otherwise: cnt[i] <= cnt[i] - 1.
- Latency: input edge captured at edge 1. signal_out and strobe update at edge SYNC_STAGES+FILTER, provided the input holds.
- Filtering: any return of sync[i] to signal_out[i] before cnt reaches 0 reloads the counter. The glitch is fully discarded.
- Strobes:
  - Registered, high exactly one cycle; cleared the following cycle unless a new update occurs.
  - rise and fall are never both high on one channel.
- Simultaneous events: channels update in the same cycle independently. Multiple strobe bits may be set together; any_change = 1 once.
- Reset mid-count: counters return to RELOAD. A full FILTER interval is needed after release.
- Counter never underflows. cnt==0 with no difference reloads via the equal branch.

Optional Feature:
Macro DEBOUNCER_BANK_LONG_PRESS_EN.
- Defined:
  - Per-channel long counter, width clogb2(LONG_FILTER), reset to LONG_FILTER-1.
  - While signal_out[i]==1, the counter decrements. On reaching 0, long_pulse[i]=1 for one cycle, then the counter holds at 0.
  - It fires once per press and reloads when signal_out[i]==0.
  - long_pulse[i] is asserted LONG_FILTER clocks after the edge where signal_out[i] rose.
- Not defined: no long counters are built; long_pulse is tied to 0. The port is always present.

Test Plan (WIDTH=4, FILTER=4, SYNC_STAGES=2, INIT_VAL=0, LONG_FILTER=8):
1. Reset check: assert rst_n=0 mid-cycle with signal_in=4'hF -> outputs read 0 immediately, no clock needed. Release with signal_in=0 -> no strobes over 20 cycles.
2. Clean rise: signal_in[0]=1, held 10 cycles -> signal_out[0] and rise_pulse[0] both go 1 at edge 6 after capture. rise_pulse high exactly 1 cycle; any_change=1 in the same cycle.
3. Glitch rejection: signal_in[1]=1 for 3 cycles, then 0 -> signal_out stays 4'h0; no strobe and no any_change.
4. Simultaneous events: from signal_out=4'h8, set signal_in=4'h4 in one cycle -> at edge 6, signal_out=4'h4, rise_pulse=4'b0100, fall_pulse=4'b1000, any_change=1.
5. Async reset mid-count: ch0 differs for 2 cycles, then pulse rst_n low between edges -> signal_out[0]=0 at once. After release with ch0 still 1, the update lands a full 6 edges later.
6. Long press: with the macro, hold ch0 high -> long_pulse[0] fires once, 8 cycles after signal_out[0] rose, and not again while held. Without the macro, long_pulse stays 0.
